router_pkt_tx: RTL and testbench

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

---
 rtl/router_pkt_tx.sv | 146 ++++++++++++++
 tb/tb_router_pkt_tx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: collects a payload from upstream into a 64-byte buffer, then
// sends header, payload and parity bytes to a router port, stalling on busy.
// Handshakes:
//   upstream : a byte moves on a rising edge where pay_valid && pay_ready.
//   router   : the byte on data_out is consumed on a rising edge where busy == 0;
//              while busy is high data_out, pkt_valid and the state hold.
// All outputs are decoded from registered state only (no input-to-output paths).
module router_pkt_tx (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] payload_len,
  input  logic [7:0] pay_data,
  input  logic       pay_valid,
  output logic       pay_ready,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_HEADER  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_PARITY  = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  parity_q, parity_d;
  logic [5:0]  len_q, len_d;
  logic [1:0]  addr_q, addr_d;
  logic        err_q, err_d;
  logic        mem_we;
  logic [7:0]  mem_q [64];
  logic [7:0]  header;

  assign header    = {len_q, addr_q};
  assign state_dbg = state_q;
  assign tx_err    = err_q;

  // Control registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      parity_q <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

  // Payload buffer; contents are don't-care after reset since each packet
  // rewrites it from index 0 before reading.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[cnt_q] <= pay_data;
  end

  // Next-state logic and registered-state output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    parity_d  = parity_q;
    len_d     = len_q;
    addr_d    = addr_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    pay_ready = 1'b0;
    data_out  = 8'h00;
    pkt_valid = 1'b0;
    tx_done   = 1'b0;
    tx_active = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((payload_len != 6'd0) && (dest_addr != 2'b11)) begin
            len_d   = payload_len;
            addr_d  = dest_addr;
            cnt_d   = 6'd0;
            state_d = S_COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        pay_ready = 1'b1;
        if (pay_valid) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == (len_q - 6'd1)) state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        data_out  = header;
        pkt_valid = 1'b1;
        if (!busy) begin
          parity_d = header;
          idx_d    = 6'd0;
          state_d  = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        data_out  = mem_q[idx_q];
        pkt_valid = 1'b1;
        if (!busy) begin
          parity_d = parity_q ^ mem_q[idx_q];
          idx_d    = idx_q + 6'd1;
          if (idx_q == (len_q - 6'd1)) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        data_out = parity_q;
        if (!busy) state_d = S_DONE;
      end
      S_DONE: begin
        tx_done = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Testbench for router_pkt_tx: directed packets plus randomized traffic,
// checked by a monitor that pops a queue of expected router-side events.
module tb_router_pkt_tx;

  logic       clock;
  logic       reset;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       pay_ready;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_active;
  logic       tx_done;
  logic       tx_err;
  logic [2:0] state_dbg;

  router_pkt_tx dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dest_addr   (dest_addr),
    .payload_len (payload_len),
    .pay_data    (pay_data),
    .pay_valid   (pay_valid),
    .pay_ready   (pay_ready),
    .busy        (busy),
    .data_out    (data_out),
    .pkt_valid   (pkt_valid),
    .tx_active   (tx_active),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int err_seen = 0;

  // Expected router-side events: {done_marker, pkt_valid, byte}.
  logic [9:0] exp_q[$];
  logic [7:0] pay_q[$];

  localparam logic [9:0] DONE_EV = 10'h200;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- busy generator ----------------
  logic busy_force = 1'b0;
  logic busy_rand  = 1'b0;

  initial busy = 1'b0;
  always @(posedge clock) begin
    #1;
    busy = busy_force | (busy_rand && ($urandom_range(0, 3) == 0));
  end

  // ---------------- reference model ----------------
  // A packet is its header {len, addr}, the payload in order, then the XOR of
  // every byte sent before it (pkt_valid low), then a completion pulse.
  task automatic expect_pkt(input logic [1:0] a, input logic [5:0] l);
    logic [7:0] hdr;
    logic [7:0] p;
    hdr = {l, a};
    p   = hdr;
    exp_q.push_back({1'b0, 1'b1, hdr});
    foreach (pay_q[i]) begin
      exp_q.push_back({1'b0, 1'b1, pay_q[i]});
      p = p ^ pay_q[i];
    end
    exp_q.push_back({1'b0, 1'b0, p});
    exp_q.push_back(DONE_EV);
  endtask

  function automatic bit start_ok(input logic [1:0] a, input logic [5:0] l);
    return (l != 0) && (a != 2'd3);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    logic [9:0] e;
    if (!reset) begin
      if (tx_err) err_seen++;
      if (!tx_active) begin
        check("idle_outputs", {pay_ready, pkt_valid, tx_done, data_out}, 32'h0);
      end else if (pay_ready) begin
        check("collect_outputs", {pkt_valid, tx_done, data_out}, 32'h0);
      end else if (tx_done) begin
        if (exp_q.size() == 0) check("done_unexpected", tx_done, 1'b0);
        else begin
          e = exp_q.pop_front();
          check("done_event", {tx_done, pkt_valid, data_out}, e);
        end
      end else if (!busy) begin
        if (exp_q.size() == 0) check("byte_unexpected", {pkt_valid, data_out}, 32'h0);
        else begin
          e = exp_q.pop_front();
          check("tx_byte", {1'b0, pkt_valid, data_out}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_start(input logic [1:0] a, input logic [5:0] l);
    @(posedge clock); #1;
    start = 1'b1; dest_addr = a; payload_len = l;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic feed_payload(input int l, input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < l && guard < 3000) begin
      @(posedge clock); #1;
      pay_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      pay_data  = pay_q[i];
      @(negedge clock);
      if (pay_valid && pay_ready) i++;
      guard++;
    end
    @(posedge clock); #1;
    pay_valid = 1'b0;
    pay_data  = 8'($urandom);
    check("feed_complete", i, l);
  endtask

  task automatic wait_done(input int budget);
    int g = 0;
    do begin
      @(negedge clock);
      g++;
    end while (!tx_done && g < budget);
    check("done_seen", tx_done, 1'b1);
  endtask

  task automatic wait_header(input logic [7:0] hdr);
    int g = 0;
    do begin
      @(negedge clock);
      g++;
    end while (!(pkt_valid && data_out == hdr) && g < 200);
    check("header_seen", {pkt_valid, data_out}, {1'b1, hdr});
  endtask

  task automatic load_abc();
    pay_q.delete();
    pay_q.push_back(8'hA1);
    pay_q.push_back(8'hB2);
    pay_q.push_back(8'hC3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int nb2;
    int e0;
    logic [1:0] a;
    logic [5:0] l;

    reset = 1'b1; start = 1'b0; dest_addr = '0; payload_len = '0;
    pay_data = '0; pay_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_state", {pay_ready, pkt_valid, tx_active, tx_done, tx_err, data_out}, 32'h0);

    // Basic packet, busy low: five consecutive bytes then completion.
    load_abc();
    expect_pkt(2'd1, 6'd3);
    issue_start(2'd1, 6'd3);
    feed_payload(3, 1'b0);
    wait_header(8'h0D);
    n = 0;
    do begin @(negedge clock); n++; end while (!tx_done && n < 100);
    check("span_len3", n, 5);

    // Same packet with busy held high three edges while B2 is on the bus.
    load_abc();
    expect_pkt(2'd1, 6'd3);
    issue_start(2'd1, 6'd3);
    feed_payload(3, 1'b0);
    n = 0;
    do begin @(negedge clock); n++; end while (!(pkt_valid && data_out == 8'hA1) && n < 200);
    check("a1_seen", {pkt_valid, data_out}, {1'b1, 8'hA1});
    busy_force = 1'b1;
    n = 0; nb2 = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == 3) busy_force = 1'b0;
      if (pkt_valid && data_out == 8'hB2) nb2++;
    end while (!tx_done && n < 100);
    check("b2_hold_cycles", nb2, 4);

    // Rejected starts: zero length, then address 3.
    for (int k = 0; k < 2; k++) begin
      e0 = err_seen;
      if (k == 0) issue_start(2'd1, 6'd0);
      else        issue_start(2'd3, 6'd5);
      repeat (3) begin
        @(negedge clock);
        check("reject_inactive", {tx_active, pkt_valid}, 2'b00);
      end
      check("reject_err_pulses", err_seen - e0, 1);
    end

    // Maximum length packet to port 2 with upstream gaps.
    pay_q.delete();
    for (int k = 0; k < 63; k++) pay_q.push_back(8'(k));
    expect_pkt(2'd2, 6'd63);
    issue_start(2'd2, 6'd63);
    feed_payload(63, 1'b1);
    wait_done(300);

    // Reset while the second payload byte is presented.
    pay_q.delete();
    for (int k = 0; k < 4; k++) pay_q.push_back(8'($urandom));
    expect_pkt(2'd0, 6'd4);
    issue_start(2'd0, 6'd4);
    feed_payload(4, 1'b0);
    wait_header(8'h10);
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("pre_reset_byte1", {pkt_valid, data_out}, {1'b1, pay_q[1]});
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("post_reset_outputs", {pkt_valid, tx_active, pay_ready, data_out}, 32'h0);
    pay_q.delete();
    for (int k = 0; k < 5; k++) pay_q.push_back(8'($urandom));
    expect_pkt(2'd2, 6'd5);
    issue_start(2'd2, 6'd5);
    feed_payload(5, 1'b1);
    wait_done(200);

    // Start held high across a packet: the next packet follows completion.
    pay_q.delete();
    pay_q.push_back(8'h5A); pay_q.push_back(8'h3C);
    expect_pkt(2'd1, 6'd2);
    @(posedge clock); #1;
    start = 1'b1; dest_addr = 2'd1; payload_len = 6'd2;
    feed_payload(2, 1'b0);
    pay_q.delete();
    pay_q.push_back(8'hE7); pay_q.push_back(8'h81);
    expect_pkt(2'd1, 6'd2);
    feed_payload(2, 1'b1);
    start = 1'b0;
    wait_done(100);
    repeat (3) begin
      @(negedge clock);
      check("no_third_packet", tx_active, 1'b0);
    end

    // Randomized traffic with random router backpressure.
    busy_rand = 1'b1;
    for (int t = 0; t < 14; t++) begin
      a = 2'($urandom_range(0, 3));
      l = ($urandom_range(0, 5) == 0) ? 6'd63 : 6'($urandom_range(0, 20));
      if (!start_ok(a, l)) begin
        e0 = err_seen;
        issue_start(a, l);
        repeat (2) @(negedge clock);
        check("rand_err_pulse", err_seen - e0, 1);
      end else begin
        pay_q.delete();
        for (int k = 0; k < int'(l); k++) pay_q.push_back(8'($urandom));
        expect_pkt(a, l);
        issue_start(a, l);
        feed_payload(int'(l), 1'b1);
        wait_done(600);
      end
    end
    busy_rand = 1'b0;

    repeat (5) @(negedge clock);
    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
